fp_mult_pipe: RTL and testbench

Pipelined, parametrised IEEE-754-style floating-point multiplier with valid/ready handshakes on input and output. It is the successor to the team's combinational single-precision multiplier in the Maxnet datapath. Additions over that block:
- configurable exponent and mantissa widths;
- full special-value handling (signed zero, infinity, NaN);
- round-to-nearest-even;
- overflow and underflow saturation;
- a 3-stage registered pipeline with backpressure.

---
 rtl/fp_mult_pipe_if.sv | 25 ++
 rtl/fp_mult_pipe.sv | 170 +++++++++++++++++
 tb/tb_fp_mult_pipe.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fp_mult_pipe_if.sv
// Handshake bundle for fp_mult_pipe: operand channel (in_valid/in_ready/a/b)
// and result channel (out_valid/out_ready/result). N is the packed float width.
interface fp_mult_pipe_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;

  // Producer/consumer side: drives operands, accepts results.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result
  );

  // Multiplier side.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/fp_mult_pipe.sv
// 3-stage pipelined floating-point multiplier, parametrised exponent/mantissa
// widths. S1 unpacks/classifies, S2 multiplies mantissas, S3 normalises,
// rounds to nearest-even, saturates and packs into the output register.
// Subnormal inputs are flushed to zero. A single global stall freezes every
// stage while the output holds an unaccepted result.
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic          clk,
  input  logic          rst,
  fp_mult_pipe_if.slave bus
);

  localparam int N    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EW2  = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;

  localparam logic signed [EW2-1:0] BIAS_E  = EW2'(BIAS);
  localparam logic signed [EW2-1:0] EXP_MAX = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] EXP_ONE = EW2'(1);
  localparam logic signed [EW2-1:0] EXP_NIL = EW2'(0);

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_e;

  // Operand fields
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;

  assign {sa, ea, ma} = bus.a;
  assign {sb, eb, mb} = bus.b;

  // Stage registers and their next-state values
  logic                  s1_v_q, s2_v_q, out_valid_q;
  logic                  s1_sign_q, s1_sign_d, s2_sign_q;
  logic signed [EW2-1:0] s1_exp_q, s1_exp_d, s2_exp_q;
  logic [MAN_W:0]        s1_ma_q, s1_mb_q;
  cls_e                  s1_cls_q, s1_cls_d, s2_cls_q;
  logic [PW-1:0]         s2_prod_d, s2_prod_q;
  logic [N-1:0]          result_q, result_d;

  logic stall;

  // A pending, unaccepted result freezes the whole pipe.
  assign stall         = out_valid_q & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

  // S1: classify operands, combine sign, form biased exponent sum.
  always_comb begin
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    a_zero    = (ea == '0);
    b_zero    = (eb == '0);
    a_inf     = (ea == '1) & (ma == '0);
    b_inf     = (eb == '1) & (mb == '0);
    a_nan     = (ea == '1) & (ma != '0);
    b_nan     = (eb == '1) & (mb != '0);
    s1_sign_d = sa ^ sb;
    s1_exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_E;
    if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
      s1_cls_d = CLS_NAN;
    end else if (a_inf | b_inf) begin
      s1_cls_d = CLS_INF;
    end else if (a_zero | b_zero) begin
      s1_cls_d = CLS_ZERO;
    end else begin
      s1_cls_d = CLS_NORM;
    end
  end

  // S2: full-width mantissa product (hidden bits included).
  always_comb begin
    s2_prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);
  end

  // S3: normalise, round nearest-even, saturate, apply special-case priority.
  always_comb begin
    logic [MAN_W-1:0]      man_n, man_r;
    logic [MAN_W:0]        man_sum;
    logic                  guard, sticky, round_up;
    logic signed [EW2-1:0] exp_n, exp_r;
    if (s2_prod_q[PW-1]) begin
      man_n  = s2_prod_q[PW-2 -: MAN_W];
      guard  = s2_prod_q[MAN_W];
      sticky = |s2_prod_q[MAN_W-1:0];
      exp_n  = s2_exp_q + EXP_ONE;
    end else begin
      man_n  = s2_prod_q[PW-3 -: MAN_W];
      guard  = s2_prod_q[MAN_W-1];
      sticky = |s2_prod_q[MAN_W-2:0];
      exp_n  = s2_exp_q;
    end
    round_up = guard & (sticky | man_n[0]);
    man_sum  = {1'b0, man_n} + {{MAN_W{1'b0}}, round_up};
    if (man_sum[MAN_W]) begin
      man_r = '0;
      exp_r = exp_n + EXP_ONE;
    end else begin
      man_r = man_sum[MAN_W-1:0];
      exp_r = exp_n;
    end
    case (s2_cls_q)
      CLS_NAN:  result_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      CLS_INF:  result_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_ZERO: result_d = {s2_sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
      CLS_NORM: begin
        if (exp_r >= EXP_MAX) begin
          result_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (exp_r <= EXP_NIL) begin
          result_d = {s2_sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
        end else begin
          result_d = {s2_sign_q, exp_r[EXP_W-1:0], man_r};
        end
      end
      default:  result_d = '0;
    endcase
  end

  // Valid bits and output register: cleared on reset, frozen on stall;
  // result only updates when a real result arrives so bubbles keep it stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q      <= 1'b0;
      s2_v_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else if (!stall) begin
      s1_v_q      <= bus.in_valid;
      s2_v_q      <= s1_v_q;
      out_valid_q <= s2_v_q;
      if (s2_v_q) begin
        result_q <= result_d;
      end
    end
  end

  // Datapath stage registers: advance whenever the pipe is not stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sign_q <= 1'b0;
      s1_exp_q  <= '0;
      s1_ma_q   <= '0;
      s1_mb_q   <= '0;
      s1_cls_q  <= CLS_ZERO;
      s2_sign_q <= 1'b0;
      s2_exp_q  <= '0;
      s2_prod_q <= '0;
      s2_cls_q  <= CLS_ZERO;
    end else if (!stall) begin
      s1_sign_q <= s1_sign_d;
      s1_exp_q  <= s1_exp_d;
      s1_ma_q   <= {1'b1, ma};
      s1_mb_q   <= {1'b1, mb};
      s1_cls_q  <= s1_cls_d;
      s2_sign_q <= s1_sign_q;
      s2_exp_q  <= s1_exp_q;
      s2_prod_q <= s2_prod_d;
      s2_cls_q  <= s1_cls_q;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed bench for fp_mult_pipe: single-precision vectors, backpressure
// streaming, mid-stream reset, and a half-precision-sized instance.
module tb_fp_mult_pipe;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fp_mult_pipe_if #(.N(32)) bus32 ();
  fp_mult_pipe_if #(.N(16)) bus16 ();

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32.slave)
  );

  fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  localparam int NV = 11;
  localparam logic [31:0] VA [NV] = '{
    32'h40000000, 32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'h7F800000, 32'hC0000000,
    32'h7FC00001, 32'hFF800000, 32'h7F000000, 32'h00800000, 32'h7F7FFFFF};
  localparam logic [31:0] VB [NV] = '{
    32'h40400000, 32'h3FC00000, 32'h3F800001, 32'h3FC00000, 32'h00000000, 32'h00000000,
    32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F000000, 32'h3F800001};
  localparam logic [31:0] VR [NV] = '{
    32'h40C00000, 32'h40100000, 32'h3F800002, 32'h3FC00002, 32'h7FC00000, 32'h80000000,
    32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'h00000000, 32'h7F800000};

  int n_checks = 0;
  int n_pass   = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Present one operand pair to the 32-bit instance; returns after acceptance edge.
  task automatic send32(input logic [31:0] a_v, input logic [31:0] b_v);
    @(negedge clk);
    bus32.in_valid = 1'b1;
    bus32.a        = a_v;
    bus32.b        = b_v;
    @(posedge clk);
    #1 bus32.in_valid = 1'b0;
  endtask

  // Wait (bounded) for the 32-bit result and check latency and value.
  task automatic wait_out32(input string tag, input logic [31:0] exp_r);
    int lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (bus32.out_valid) lat = i;
    end
    check({tag, "_lat"}, lat, 32'd3);
    check(tag, bus32.result, exp_r);
  endtask

  // Same pair of steps for the 16-bit instance.
  task automatic run16(input string tag, input logic [15:0] a_v, input logic [15:0] b_v,
                       input logic [15:0] exp_r);
    int lat = 0;
    @(negedge clk);
    bus16.in_valid = 1'b1;
    bus16.a        = a_v;
    bus16.b        = b_v;
    @(posedge clk);
    #1 bus16.in_valid = 1'b0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (bus16.out_valid) lat = i;
    end
    check({tag, "_lat"}, lat, 32'd3);
    check(tag, {16'h0, bus16.result}, {16'h0, exp_r});
  endtask

  // Hard stop if anything above fails to terminate.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int          in_idx;
    int          out_idx;
    logic        stalled_prev;
    logic        rdy_exp;
    logic [31:0] prev_res;

    rst             = 1'b1;
    bus32.in_valid  = 1'b0;
    bus32.a         = '0;
    bus32.b         = '0;
    bus32.out_ready = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.a         = '0;
    bus16.b         = '0;
    bus16.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus32.out_valid, 32'd0);
    check("rst_result", bus32.result, 32'd0);
    check("rst_in_ready", bus32.in_ready, 32'd1);
    rst = 1'b0;

    // Directed vectors, one at a time with out_ready held high
    for (int i = 0; i < NV; i++) begin
      send32(VA[i], VB[i]);
      wait_out32($sformatf("vec%0d", i), VR[i]);
    end

    // Backpressure: 8 back-to-back pairs, random out_ready
    in_idx       = 0;
    out_idx      = 0;
    stalled_prev = 1'b0;
    prev_res     = '0;
    for (int cyc = 0; cyc < 300 && out_idx < 8; cyc++) begin
      @(negedge clk);
      bus32.out_ready = 1'($urandom_range(0, 1));
      if (in_idx < 8) begin
        bus32.in_valid = 1'b1;
        bus32.a        = VA[in_idx];
        bus32.b        = VB[in_idx];
      end else begin
        bus32.in_valid = 1'b0;
      end
      #1;
      rdy_exp = !(bus32.out_valid && !bus32.out_ready);
      check("bp_in_ready", bus32.in_ready, rdy_exp);
      if (stalled_prev) begin
        check("bp_hold_valid", bus32.out_valid, 32'd1);
        check("bp_hold_result", bus32.result, prev_res);
      end
      if (bus32.out_valid && bus32.out_ready) begin
        check($sformatf("bp_res%0d", out_idx), bus32.result, VR[out_idx]);
        out_idx++;
      end
      stalled_prev = bus32.out_valid & ~bus32.out_ready;
      prev_res     = bus32.result;
      if (bus32.in_valid && bus32.in_ready) in_idx++;
    end
    check("bp_count", out_idx, 32'd8);
    @(negedge clk);
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("bp_no_extra", bus32.out_valid, 32'd0);

    // Reset mid-stream: two accepted, reset, then a third
    @(negedge clk);
    bus32.in_valid = 1'b1;
    bus32.a        = VA[0];
    bus32.b        = VB[0];
    @(posedge clk);
    #1;
    bus32.a = VA[1];
    bus32.b = VB[1];
    @(posedge clk);
    #1;
    bus32.in_valid = 1'b0;
    rst            = 1'b1;
    check("mrst_in_ready_during", bus32.in_ready, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mrst_out_valid", bus32.out_valid, 32'd0);
    check("mrst_result", bus32.result, 32'd0);
    check("mrst_in_ready", bus32.in_ready, 32'd1);
    send32(VA[2], VB[2]);
    wait_out32("mrst_next", VR[2]);

    // Reduced-width instance
    run16("p16_mul", 16'h4000, 16'h4200, 16'h4600);
    run16("p16_ovf", 16'h7800, 16'h4000, 16'h7C00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
